// File: rtl/cosim_loopback_pkg.sv
// Shared types and the token transform for the cosim loopback responder.
// Tokens are handled in a MaxTokenW-wide container; callers slice back to their own width.
package cosim_loopback_pkg;

    typedef enum logic [1:0] {
        ECHO   = 2'd0,
        INVERT = 2'd1,
        INCR   = 2'd2,
        PAUSE  = 2'd3
    } loopback_mode_e;

    localparam int unsigned MaxTokenW = 1024;

    // Result bits above 'width' are forced to zero so INCR wraps modulo 2^width.
    function automatic logic [MaxTokenW-1:0] apply_mode(loopback_mode_e mode,
                                                        logic [MaxTokenW-1:0] data,
                                                        int unsigned width);
        logic [MaxTokenW-1:0] mask;
        logic [MaxTokenW-1:0] res;
        mask = '1;
        mask = mask >> (MaxTokenW - width);
        case (mode)
            INVERT:  res = ~data;
            INCR:    res = data + MaxTokenW'(1);
            default: res = data;
        endcase
        return res & mask;
    endfunction

endpackage

// File: rtl/loopback_chan_fifo.sv
// One loopback channel: transform-on-accept, DEPTH-entry FIFO, and token counters.
// No combinational path from the rx side to the tx side.
module loopback_chan_fifo
    import cosim_loopback_pkg::*;
#(
    parameter int unsigned W     = 24,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 32,
    localparam int unsigned OccW = $clog2(DEPTH + 1),
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  loopback_mode_e   mode,
    input  logic             rxValid,
    output logic             rxReady,
    input  logic [W-1:0]     rxData,
    output logic             txValid,
    input  logic             txReady,
    output logic [W-1:0]     txData,
    output logic [OccW-1:0]  occupancy,
    output logic [CNT_W-1:0] rxCount,
    output logic [CNT_W-1:0] txCount
);

    logic [W-1:0]         mem [DEPTH];
    logic [PtrW-1:0]      wrPtr, rdPtr;
    logic [OccW-1:0]      occ;
    logic [CNT_W-1:0]     rxCnt, txCnt;
    logic                 full, empty, push, pop;
    logic [MaxTokenW-1:0] xformWide;
    logic [W-1:0]         xform;
    logic                 unused_xformHi;

    function automatic logic [PtrW-1:0] nextPtr(logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full    = (occ == OccW'(DEPTH));
    assign empty   = (occ == '0);
    assign rxReady = rstn && !full && (mode != PAUSE);
    assign txValid = !empty;
    assign txData  = empty ? '0 : mem[rdPtr];
    assign push    = rxValid && rxReady;
    assign pop     = txValid && txReady;

    assign xformWide      = apply_mode(mode, MaxTokenW'(rxData), W);
    assign xform          = xformWide[W-1:0];
    assign unused_xformHi = ^xformWide[MaxTokenW-1:W];

    assign occupancy = occ;
    assign rxCount   = rxCnt;
    assign txCount   = txCnt;

    // Storage is not reset; push is held low during reset through rxReady.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= xform;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            occ   <= '0;
            rxCnt <= '0;
            txCnt <= '0;
        end else begin
            if (push) begin
                wrPtr <= nextPtr(wrPtr);
                rxCnt <= rxCnt + CNT_W'(1);
            end
            if (pop) begin
                rdPtr <= nextPtr(rdPtr);
                txCnt <= txCnt + CNT_W'(1);
            end
            if (push && !pop) begin
                occ <= occ + OccW'(1);
            end else if (pop && !push) begin
                occ <= occ - OccW'(1);
            end
        end
    end

endmodule

// File: rtl/cosim_loopback_array.sv
// NUM_CH independent loopback channels between a cosim endpoint's DataOut and DataIn pairs.
// Only bus packing lives here; all behaviour is in loopback_chan_fifo.
module cosim_loopback_array
    import cosim_loopback_pkg::*;
#(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned TYPE_SIZE_BITS = 24,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned CNT_W          = 32,
    localparam int unsigned OccW          = $clog2(DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_CH-1:0]                rx_valid,
    output logic [NUM_CH-1:0]                rx_ready,
    input  logic [NUM_CH*TYPE_SIZE_BITS-1:0] rx_data,
    output logic [NUM_CH-1:0]                tx_valid,
    input  logic [NUM_CH-1:0]                tx_ready,
    output logic [NUM_CH*TYPE_SIZE_BITS-1:0] tx_data,
    input  logic [2*NUM_CH-1:0]              mode,
    output logic [NUM_CH*OccW-1:0]           occupancy,
    output logic [NUM_CH*CNT_W-1:0]          rx_count,
    output logic [NUM_CH*CNT_W-1:0]          tx_count
);

    for (genvar c = 0; c < NUM_CH; c++) begin : gCh
        loopback_chan_fifo #(
            .W     (TYPE_SIZE_BITS),
            .DEPTH (DEPTH),
            .CNT_W (CNT_W)
        ) uChan (
            .clk       (clk),
            .rstn      (rstn),
            .mode      (loopback_mode_e'(mode[2*c +: 2])),
            .rxValid   (rx_valid[c]),
            .rxReady   (rx_ready[c]),
            .rxData    (rx_data[c*TYPE_SIZE_BITS +: TYPE_SIZE_BITS]),
            .txValid   (tx_valid[c]),
            .txReady   (tx_ready[c]),
            .txData    (tx_data[c*TYPE_SIZE_BITS +: TYPE_SIZE_BITS]),
            .occupancy (occupancy[c*OccW +: OccW]),
            .rxCount   (rx_count[c*CNT_W +: CNT_W]),
            .txCount   (tx_count[c*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_cosim_loopback_array.sv
// Bench for cosim_loopback_array: queue-based per-channel model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cosim_loopback_array;

    localparam int NCH   = 2;
    localparam int W     = 24;
    localparam int DEPTH = 4;
    localparam int CNTW  = 4;
    localparam int OCCW  = 3;

    logic                clk;
    logic                rstn;
    logic [NCH-1:0]      rx_valid, rx_ready, tx_valid, tx_ready;
    logic [NCH*W-1:0]    rx_data, tx_data;
    logic [2*NCH-1:0]    mode;
    logic [NCH*OCCW-1:0] occupancy;
    logic [NCH*CNTW-1:0] rx_count, tx_count;

    int nCmp;
    int nErr;
    bit checkEn;

    logic [W-1:0] mq [NCH][$];
    int unsigned  mRx [NCH];
    int unsigned  mTx [NCH];
    bit           mPushed [NCH];

    cosim_loopback_array #(
        .NUM_CH         (NCH),
        .TYPE_SIZE_BITS (W),
        .DEPTH          (DEPTH),
        .CNT_W          (CNTW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .mode      (mode),
        .occupancy (occupancy),
        .rx_count  (rx_count),
        .tx_count  (tx_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] txd(int c);
        return tx_data[c*W +: W];
    endfunction
    function automatic logic [OCCW-1:0] occ(int c);
        return occupancy[c*OCCW +: OCCW];
    endfunction
    function automatic logic [CNTW-1:0] rxc(int c);
        return rx_count[c*CNTW +: CNTW];
    endfunction
    function automatic logic [CNTW-1:0] txc(int c);
        return tx_count[c*CNTW +: CNTW];
    endfunction

    function automatic logic [W-1:0] modelXform(logic [1:0] m, logic [W-1:0] d);
        longint v;
        if (m == 2'd1) return ~d;
        if (m == 2'd2) begin
            v = (longint'(d) + 1) % (longint'(1) << W);
            return v[W-1:0];
        end
        return d;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setMode(int c, logic [1:0] m);
        mode[2*c +: 2] = m;
    endtask

    task automatic sendTok(int c, logic [W-1:0] d, int maxCyc);
        bit done;
        done = 1'b0;
        rx_valid[c] = 1'b1;
        rx_data[c*W +: W] = d;
        for (int i = 0; i < maxCyc && !done; i++) begin
            step();
            done = mPushed[c];
        end
        rx_valid[c] = 1'b0;
        chk($sformatf("ch%0d token %0h accepted", c, d), 64'(done), 64'd1);
    endtask

    task automatic drain(int c, int maxCyc);
        for (int i = 0; i < maxCyc && mq[c].size() != 0; i++) step();
        chk($sformatf("ch%0d drained", c), 64'(mq[c].size()), 64'd0);
    endtask

    // Reference model: updated on each posedge from the inputs applied before that edge.
    initial forever begin
        @(posedge clk);
        for (int c = 0; c < NCH; c++) begin
            bit doPush;
            bit doPop;
            mPushed[c] = 1'b0;
            if (!rstn) begin
                mq[c].delete();
                mRx[c] = 0;
                mTx[c] = 0;
            end else begin
                doPush = rx_valid[c] && (mq[c].size() < DEPTH) && (mode[2*c +: 2] != 2'd3);
                doPop  = tx_ready[c] && (mq[c].size() != 0);
                if (doPop) begin
                    void'(mq[c].pop_front());
                    mTx[c]++;
                end
                if (doPush) begin
                    mq[c].push_back(modelXform(mode[2*c +: 2], rx_data[c*W +: W]));
                    mRx[c]++;
                end
                mPushed[c] = doPush;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (checkEn) begin
            for (int c = 0; c < NCH; c++) begin
                logic [W-1:0] expData;
                logic         expReady;
                expData  = (mq[c].size() != 0) ? mq[c][0] : '0;
                expReady = rstn && (mq[c].size() < DEPTH) && (mode[2*c +: 2] != 2'd3);
                chk($sformatf("ch%0d tx_valid", c), 64'(tx_valid[c]), 64'(mq[c].size() != 0));
                chk($sformatf("ch%0d tx_data", c), 64'(txd(c)), 64'(expData));
                chk($sformatf("ch%0d occupancy", c), 64'(occ(c)), 64'(mq[c].size()));
                chk($sformatf("ch%0d rx_ready", c), 64'(rx_ready[c]), 64'(expReady));
                chk($sformatf("ch%0d rx_count", c), 64'(rxc(c)), 64'(mRx[c] % 16));
                chk($sformatf("ch%0d tx_count", c), 64'(txc(c)), 64'(mTx[c] % 16));
            end
        end
    end

    initial begin
        int accRx;
        int accTx;
        nCmp = 0;
        nErr = 0;
        checkEn = 1'b0;
        rstn = 1'b0;
        rx_valid = '0;
        tx_ready = '0;
        rx_data = '0;
        mode = '0;
        step();
        checkEn = 1'b1;
        step();
        rstn = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("reset ch%0d tx_valid", c), 64'(tx_valid[c]), 64'd0);
            chk($sformatf("reset ch%0d occupancy", c), 64'(occ(c)), 64'd0);
            chk($sformatf("reset ch%0d rx_count", c), 64'(rxc(c)), 64'd0);
        end

        // Echo of a single token on ch0.
        tx_ready[0] = 1'b1;
        sendTok(0, 24'hDEADBE, 4);
        chk("echo tx_valid", 64'(tx_valid[0]), 64'd1);
        chk("echo tx_data", 64'(txd(0)), 64'hDEADBE);
        step();
        chk("echo rx_count", 64'(rxc(0)), 64'd1);
        chk("echo tx_count", 64'(txc(0)), 64'd1);
        chk("echo occupancy", 64'(occ(0)), 64'd0);

        // Fill and backpressure.
        tx_ready[0] = 1'b0;
        for (int i = 1; i <= 4; i++) sendTok(0, W'(i), 4);
        rx_valid[0] = 1'b1;
        rx_data[0 +: W] = 24'd5;
        step();
        step();
        chk("full occupancy", 64'(occ(0)), 64'd4);
        chk("full rx_ready", 64'(rx_ready[0]), 64'd0);
        chk("full head", 64'(txd(0)), 64'd1);
        tx_ready[0] = 1'b1;
        sendTok(0, 24'd5, 4);
        chk("refill head", 64'(txd(0)), 64'd3);
        drain(0, 8);

        // Modes on ch1.
        tx_ready[1] = 1'b1;
        setMode(1, 2'd1);
        sendTok(1, 24'h00FF00, 4);
        chk("invert data", 64'(txd(1)), 64'hFF00FF);
        setMode(1, 2'd2);
        sendTok(1, 24'hFFFFFF, 4);
        chk("incr wrap valid", 64'(tx_valid[1]), 64'd1);
        chk("incr wrap data", 64'(txd(1)), 64'h000000);
        sendTok(1, 24'h000010, 4);
        chk("incr data", 64'(txd(1)), 64'h000011);
        step();
        tx_ready[1] = 1'b0;
        setMode(1, 2'd0);
        sendTok(1, 24'hA5A5A5, 4);
        sendTok(1, 24'h5A0001, 4);
        setMode(1, 2'd1);
        step();
        step();
        chk("switch occupancy", 64'(occ(1)), 64'd2);
        tx_ready[1] = 1'b1;
        chk("switch tok0", 64'(txd(1)), 64'hA5A5A5);
        step();
        chk("switch tok1", 64'(txd(1)), 64'h5A0001);
        step();
        chk("switch empty", 64'(tx_valid[1]), 64'd0);
        setMode(1, 2'd0);

        // Pause while draining.
        tx_ready[0] = 1'b0;
        sendTok(0, 24'h11, 4);
        sendTok(0, 24'h22, 4);
        sendTok(0, 24'h33, 4);
        setMode(0, 2'd3);
        rx_valid[0] = 1'b1;
        rx_data[0 +: W] = 24'h44;
        step();
        chk("pause rx_ready", 64'(rx_ready[0]), 64'd0);
        chk("pause occupancy", 64'(occ(0)), 64'd3);
        tx_ready[0] = 1'b1;
        step();
        step();
        step();
        chk("pause drained", 64'(occ(0)), 64'd0);
        chk("pause rx_ready end", 64'(rx_ready[0]), 64'd0);
        chk("pause rx_count", 64'(rxc(0)), 64'd9);
        chk("pause tx_count", 64'(txc(0)), 64'd9);
        rx_valid[0] = 1'b0;
        setMode(0, 2'd0);

        // Reset mid-stream, then counter wrap.
        tx_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) sendTok(0, W'(24'h100 + i), 4);
        chk("pre-reset occupancy", 64'(occ(0)), 64'd3);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("post-reset tx_valid", 64'(tx_valid[0]), 64'd0);
        chk("post-reset occupancy", 64'(occ(0)), 64'd0);
        chk("post-reset rx_count", 64'(rxc(0)), 64'd0);
        chk("post-reset tx_count", 64'(txc(0)), 64'd0);
        chk("post-reset ch1 rx_count", 64'(rxc(1)), 64'd0);
        step();
        chk("post-reset tx_valid+1", 64'(tx_valid[0]), 64'd0);
        tx_ready[0] = 1'b1;
        for (int i = 0; i < 17; i++) sendTok(0, W'(24'h200 + i), 4);
        step();
        chk("wrap rx_count", 64'(rxc(0)), 64'd1);
        chk("wrap tx_count", 64'(txc(0)), 64'd1);

        // Channel independence: ch0 stalled full, ch1 streaming.
        tx_ready[0] = 1'b0;
        for (int i = 0; i < 4; i++) sendTok(0, W'(24'hB0 + i), 4);
        tx_ready[1] = 1'b1;
        rx_valid[1] = 1'b1;
        accRx = 0;
        accTx = 0;
        for (int i = 0; i < 100; i++) begin
            rx_data[W +: W] = W'(1000 + i);
            #4;
            if (rx_ready[1]) accRx++;
            if (tx_valid[1]) accTx++;
            step();
        end
        rx_valid[1] = 1'b0;
        chk("ch1 rx rate", 64'(accRx), 64'd100);
        chk("ch1 tx rate", 64'(accTx), 64'd99);
        chk("ch0 held occupancy", 64'(occ(0)), 64'd4);
        chk("ch0 held head", 64'(txd(0)), 64'hB0);
        step();
        chk("ch1 rx_count", 64'(rxc(1)), 64'd4);
        chk("ch1 tx_count", 64'(txc(1)), 64'd4);
        tx_ready[0] = 1'b1;
        drain(0, 8);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
